// File: rtl/sar_mag_search.sv
// Successive-approximation search driving an external magnitude comparator.
// Recovers the unknown operand A MSB first, with early exit on equality.
module sar_mag_search #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             alb,
  input  logic             agb,
  input  logic             aeb,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0]    TOP = BW'(WIDTH-1);
  localparam logic [2:0]       LAST = 3'(SETTLE);

  typedef enum logic [1:0] {
    IDLE,
    TRIAL,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] cur_bit;
  logic [WIDTH-1:0] adj;
  logic             flags_ok;

  // Trial arithmetic: current bit mask and probe after the keep/clear decision
  always_comb begin
    cur_bit  = LSB << bit_q;
    adj      = alb ? (probe_q & ~cur_bit) : probe_q;
    flags_ok = 1'b0;
    unique case ({alb, agb, aeb})
      3'b100, 3'b010, 3'b001: flags_ok = 1'b1;
      default:                flags_ok = 1'b0;
    endcase
  end

  // Next-state and datapath updates for the search FSM
  always_comb begin
    state_d  = state_q;
    probe_d  = probe_q;
    result_d = result_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = TRIAL;
          probe_d = MSB;
          bit_d   = TOP;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      TRIAL: begin
        if (cnt_q != LAST) begin
          cnt_d = cnt_q + 3'd1;
        end else if (!flags_ok) begin
          err_d    = 1'b1;
          result_d = '0;
          probe_d  = '0;
          state_d  = DONE;
        end else if (aeb) begin
          result_d = probe_q;
          probe_d  = '0;
          state_d  = DONE;
        end else if (bit_q == '0) begin
          result_d = adj;
          probe_d  = '0;
          state_d  = DONE;
        end else begin
          probe_d = adj | (cur_bit >> 1);
          bit_d   = bit_q - BW'(1);
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        probe_d = '0;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      probe_q  <= '0;
      result_q <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign probe  = probe_q;
  assign busy   = (state_q == TRIAL);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_mag_search.sv
// Randomized bench for sar_mag_search against a behavioural binary-search
// model; comparator is modelled combinationally from the current probe.
module tb_sar_mag_search;

  localparam int W = 8;
  localparam int S = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         alb, agb, aeb;
  logic [W-1:0] probe, result;
  logic         busy, done, err;

  int  a_val = 0;
  bit  bad = 1'b0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  model_res = 0;

  sar_mag_search #(.WIDTH(W), .SETTLE(S)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .alb    (alb),
    .agb    (agb),
    .aeb    (aeb),
    .probe  (probe),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;

  assign alb = bad ? 1'b1 : (a_val < int'(probe));
  assign agb = bad ? 1'b1 : (a_val > int'(probe));
  assign aeb = bad ? 1'b0 : (a_val == int'(probe));

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // probe of trial t: bits of A above position k, plus bit k set
  function automatic int exp_probe(input int a, input int t);
    int k;
    if (t >= W) return 0;
    k = W - 1 - t;
    return ((a >> (k + 1)) << (k + 1)) | (1 << k);
  endfunction

  // binary search ends when the probe equals A: at A's lowest set bit
  function automatic int exp_trials(input int a);
    if (a == 0) return W;
    for (int i = 0; i < W; i++)
      if (a[i]) return W - i;
    return W;
  endfunction

  task automatic run_search(input int a, input bit inject);
    int  c;
    int  t;
    int  done_c;
    int  n_tr;
    int  e_res;
    int  e_err;
    int  lim;
    a_val  = a;
    bad    = inject;
    n_tr   = inject ? 1 : exp_trials(a);
    e_res  = inject ? 0 : a;
    e_err  = inject ? 1 : 0;
    lim    = W * (S + 1) + 5;
    c      = 0;
    done_c = 0;
    @(negedge clk);
    start = 1'b1;
    while (done_c == 0 && c < lim) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (inject && c == S + 2) bad = 1'b0;
      if (done) begin
        done_c = c;
        check("done_busy", int'(busy), 0);
        check("done_probe", int'(probe), 0);
        check("result", int'(result), e_res);
        check("err", int'(err), e_err);
        start = 1'b1;
      end else begin
        t = (c - 1) / (S + 1);
        check("busy", int'(busy), 1);
        check("probe", int'(probe), exp_probe(a, t));
        check("res_held", int'(result), model_res);
        check("err_clr", int'(err), 0);
      end
    end
    bad = 1'b0;
    check("done_cycle", done_c, n_tr * (S + 1) + 1);
    model_res = e_res;
    @(negedge clk);
    start = 1'b0;
    check("idle_done", int'(done), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_probe", int'(probe), 0);
    check("idle_res", int'(result), model_res);
    @(negedge clk);
    check("no_restart", int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_probe", int'(probe), 0);
    check("rst_res", int'(result), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;

    run_search(8'h3F, 1'b0);
    run_search(8'h80, 1'b0);
    run_search(8'h00, 1'b0);
    run_search(8'hFF, 1'b0);
    run_search(8'h01, 1'b0);
    run_search(8'h5A, 1'b1);
    run_search(8'h5A, 1'b0);
    for (int i = 0; i < 24; i++)
      run_search(int'($urandom_range(0, (1 << W) - 1)), 1'b0);
    run_search(8'h21, 1'b1);

    // start while busy is ignored; reset mid-search clears everything
    run_search(8'h77, 1'b0);
    a_val = 8'h3D;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = (c == 5);
      rst   = (c == 7);
      if (c == 6) begin
        check("ign_busy", int'(busy), 1);
        check("ign_probe", int'(probe), exp_probe(8'h3D, 2));
      end
    end
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_probe", int'(probe), 0);
    check("mid_rst_res", int'(result), 0);
    check("mid_rst_err", int'(err), 0);
    model_res = 0;
    run_search(8'h3D, 1'b0);

    // reset has priority over start
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", int'(busy), 0);
    check("rst_start_res", int'(result), 0);
    @(negedge clk);
    check("rst_start_idle", int'(busy), 0);
    model_res = 0;
    run_search(8'h80, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
